// File: rtl/cpu_alu_if.sv
// Operand/result bus of the multi-cycle ALU: valid/ready on both sides plus status.
interface cpu_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;
  logic             illegal;
  logic             busy;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, flags, illegal, busy
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, flags, illegal, busy
  );
endinterface

// File: rtl/cpu_alu_seq.sv
// Multi-cycle ALU: single-cycle add/sub/logic/shift, iterative unsigned multiply,
// {V,C,N,Z} flags, one output register behind valid/ready.
module cpu_alu_seq #(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  cpu_alu_if.slave  bus
);
  localparam int ITER  = WIDTH / MUL_STEP;
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int SH_W  = $clog2(WIDTH);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_MULH = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_SHL  = 4'd7;
  localparam logic [3:0] OP_SHR  = 4'd8;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  logic [0:0]         state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic               mulh_reg;
  logic               out_valid_reg;
  logic [WIDTH-1:0]   result_reg;
  logic [3:0]         flags_reg;
  logic               illegal_reg;

  logic in_ready;
  logic accept;
  logic is_mul_op;

  assign in_ready  = (state_reg == S_IDLE) && !flush && (!out_valid_reg || bus.out_ready);
  assign accept    = bus.in_valid && in_ready;
  assign is_mul_op = (bus.op == OP_MUL) || (bus.op == OP_MULH);

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_reg;
  assign bus.result    = result_reg;
  assign bus.flags     = flags_reg;
  assign bus.illegal   = illegal_reg;
  assign bus.busy      = (state_reg == S_MUL);

  // Single-cycle datapath; the extra top/bottom bit of each extended value is the carry.
  logic [SH_W-1:0]  sh_amt;
  logic [WIDTH:0]   add_ext;
  logic [WIDTH:0]   sub_ext;
  logic [WIDTH:0]   shl_ext;
  logic [WIDTH:0]   shr_ext;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic             alu_ill;
  logic [3:0]       alu_flags;

  always_comb begin
    sh_amt  = bus.b[SH_W-1:0];
    add_ext = {1'b0, bus.a} + {1'b0, bus.b};
    sub_ext = {1'b0, bus.a} + {1'b0, ~bus.b} + (WIDTH+1)'(1);
    shl_ext = {1'b0, bus.a} << sh_amt;
    shr_ext = {bus.a, 1'b0} >> sh_amt;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ill = 1'b0;
    case (bus.op)
      OP_ADD: begin
        alu_res = add_ext[WIDTH-1:0];
        alu_c   = add_ext[WIDTH];
        alu_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (add_ext[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_ext[WIDTH-1:0];
        alu_c   = sub_ext[WIDTH];
        alu_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sub_ext[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND: alu_res = bus.a & bus.b;
      OP_OR:  alu_res = bus.a | bus.b;
      OP_XOR: alu_res = bus.a ^ bus.b;
      OP_SHL: begin
        alu_res = shl_ext[WIDTH-1:0];
        alu_c   = shl_ext[WIDTH];
      end
      OP_SHR: begin
        alu_res = shr_ext[WIDTH:1];
        alu_c   = shr_ext[0];
      end
      OP_MUL, OP_MULH: alu_res = '0;
      default: alu_ill = 1'b1;
    endcase
    if (alu_ill) alu_flags = 4'b0000;
    else         alu_flags = {alu_v, alu_c, alu_res[WIDTH-1], (alu_res == '0)};
  end

  // One MUL_STEP-wide digit of B per cycle, weighted by its position.
  logic [MUL_STEP-1:0]       b_digit;
  logic [WIDTH+MUL_STEP-1:0] pp;
  logic [2*WIDTH-1:0]        acc_add;
  logic [2*WIDTH-1:0]        acc_next;
  logic [WIDTH-1:0]          mul_hi;
  logic [WIDTH-1:0]          mul_res;
  logic                      mul_c;
  logic [3:0]                mul_flags;

  always_comb begin
    b_digit   = b_reg[cnt_reg*MUL_STEP +: MUL_STEP];
    pp        = {{MUL_STEP{1'b0}}, a_reg} * {{WIDTH{1'b0}}, b_digit};
    acc_add   = {{(WIDTH-MUL_STEP){1'b0}}, pp} << (cnt_reg * MUL_STEP);
    acc_next  = acc_reg + acc_add;
    mul_hi    = acc_next[2*WIDTH-1:WIDTH];
    mul_res   = mulh_reg ? mul_hi : acc_next[WIDTH-1:0];
    mul_c     = !mulh_reg && (mul_hi != '0);
    mul_flags = {mul_c, mul_c, mul_res[WIDTH-1], (mul_res == '0)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      acc_reg       <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      mulh_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      flags_reg     <= '0;
      illegal_reg   <= 1'b0;
    end else if (flush) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      if (out_valid_reg && bus.out_ready) out_valid_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            if (is_mul_op) begin
              a_reg     <= bus.a;
              b_reg     <= bus.b;
              mulh_reg  <= (bus.op == OP_MULH);
              acc_reg   <= '0;
              cnt_reg   <= '0;
              state_reg <= S_MUL;
            end else begin
              result_reg    <= alu_res;
              flags_reg     <= alu_flags;
              illegal_reg   <= alu_ill;
              out_valid_reg <= 1'b1;
            end
          end
        end
        S_MUL: begin
          acc_reg <= acc_next;
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_LAST) begin
            result_reg    <= mul_res;
            flags_reg     <= mul_flags;
            illegal_reg   <= 1'b0;
            out_valid_reg <= 1'b1;
            cnt_reg       <= '0;
            state_reg     <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end
endmodule
